// File: rtl/dpd_unpack_seq_if.sv
// Operand-in / unpacked-result-out handshake bundle for dpd_unpack_seq.
// Widths follow the decimal interchange format selected by W.
interface dpd_unpack_seq_if #(
  parameter int W = 32
);
  localparam int ECW = (W == 64) ? 8 : 6;
  localparam int ND  = (W == 64) ? 5 : 2;
  localparam int EW  = ECW + 2;
  localparam int MW  = 4 * (3 * ND + 1);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  operand;
  logic          out_valid;
  logic          out_ready;
  logic          S;
  logic [EW-1:0] E;
  logic [MW-1:0] M;
  logic          is_inf;
  logic          is_nan;
  logic          is_snan;

  modport master (
    output in_valid, operand, out_ready,
    input  in_ready, out_valid, S, E, M,
    input  is_inf, is_nan, is_snan
  );

  modport slave (
    input  in_valid, operand, out_ready,
    output in_ready, out_valid, S, E, M,
    output is_inf, is_nan, is_snan
  );
endinterface

// File: rtl/dpd_unpack_seq.sv
// Sequential DPD unpacker for decimal32/decimal64 operands.
// The combination field resolves on accept; one declet expands per clock.
module dpd_unpack_seq #(
  parameter int W = 32
) (
  input logic             clk,
  input logic             rst,
  dpd_unpack_seq_if.slave bus
);
  localparam int ECW = (W == 64) ? 8 : 6;
  localparam int ND  = (W == 64) ? 5 : 2;
  localparam int EW  = ECW + 2;
  localparam int MW  = 4 * (3 * ND + 1);
  localparam int DW  = 10 * ND;
  localparam int IW  = $clog2(MW);
  localparam logic [2:0] LAST = 3'(ND - 1);

  if (W != 32 && W != 64) begin : g_bad_w
    $error("dpd_unpack_seq: W must be 32 or 64");
  end

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [2:0]    cnt;
  logic [DW-1:0] dec_q;
  logic          s_q;
  logic [EW-1:0] e_q;
  logic [MW-1:0] m_q;
  logic          inf_q;
  logic          nan_q;
  logic          snan_q;

  logic           take;
  logic [4:0]     g;
  logic [ECW-1:0] ec;
  logic [11:0]    bcd;
  logic [IW-1:0]  lo;

  function automatic logic [11:0] dpd(input logic [9:0] b);
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    h = {1'b0, b[9:7]};
    t = {1'b0, b[6:4]};
    o = {1'b0, b[2:0]};
    if (b[3]) begin
      unique case (b[2:1])
        2'b00: o = {3'b100, b[0]};
        2'b01: begin
          t = {3'b100, b[4]};
          o = {1'b0, b[6:5], b[0]};
        end
        2'b10: begin
          h = {3'b100, b[7]};
          o = {1'b0, b[9:8], b[0]};
        end
        default: begin
          o = {3'b100, b[0]};
          unique case (b[6:5])
            2'b00: begin
              h = {3'b100, b[7]};
              t = {3'b100, b[4]};
              o = {1'b0, b[9:8], b[0]};
            end
            2'b01: begin
              h = {3'b100, b[7]};
              t = {1'b0, b[9:8], b[4]};
            end
            2'b10: t = {3'b100, b[4]};
            // b9:8 are don't-care here
            default: begin
              h = {3'b100, b[7]};
              t = {3'b100, b[4]};
            end
          endcase
        end
      endcase
    end
    return {h, t, o};
  endfunction

  assign take = bus.in_valid && (state == IDLE);
  assign g    = bus.operand[W-2 -: 5];
  assign ec   = bus.operand[W-7 -: ECW];
  assign bcd  = dpd(dec_q[DW-1 -: 10]);
  assign lo   = IW'(MW - 16 - 12 * int'(cnt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nx = DECODE;
      DECODE:  if (cnt == LAST) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      dec_q  <= '0;
      s_q    <= 1'b0;
      e_q    <= '0;
      m_q    <= '0;
      inf_q  <= 1'b0;
      nan_q  <= 1'b0;
      snan_q <= 1'b0;
    end else if (take) begin
      cnt    <= '0;
      dec_q  <= bus.operand[DW-1:0];
      s_q    <= bus.operand[W-1];
      e_q    <= '0;
      m_q    <= '0;
      inf_q  <= 1'b0;
      nan_q  <= 1'b0;
      snan_q <= 1'b0;
      unique case (1'b1)
        g[4:3] != 2'b11: begin
          e_q           <= {g[4:3], ec};
          m_q[MW-1 -: 4] <= {1'b0, g[2:0]};
        end
        g[4:3] == 2'b11 && g[2:1] != 2'b11: begin
          e_q           <= {g[2:1], ec};
          m_q[MW-1 -: 4] <= {3'b100, g[0]};
        end
        g == 5'b11110: inf_q <= 1'b1;
        g == 5'b11111: begin
          nan_q  <= 1'b1;
          snan_q <= bus.operand[W-7];
        end
      endcase
    end else if (state == DECODE) begin
      // infinity keeps an all-zero coefficient
      if (!inf_q) m_q[lo +: 12] <= bcd;
      dec_q <= dec_q << 10;
      cnt   <= cnt + 3'd1;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.S         = s_q;
  assign bus.E         = e_q;
  assign bus.M         = m_q;
  assign bus.is_inf    = inf_q;
  assign bus.is_nan    = nan_q;
  assign bus.is_snan   = snan_q;
endmodule

// File: doc/dpd_unpack_seq.md
Name: dpd_unpack_seq

Overview:
- Sequential, parametrised DPD (densely-packed-decimal) unpacker for IEEE 754-2008 decimal interchange operands.
- Takes one decimal32 or decimal64 word and produces sign, biased binary exponent and BCD coefficient.
- Decodes one declet per cycle behind a valid/ready handshake.
- Flags infinity, quiet NaN and signalling NaN.
- Sits at the front of the decimal adder/subtractor datapath, one instance per operand.

Parameters:
- W, 32, operand width; legal values 32 (decimal32) and 64 (decimal64). Any other value is an elaboration error.
- ECW, derived, exponent-continuation width: 6 when W=32, 8 when W=64.
- ND, derived, declet count: 2 when W=32, 5 when W=64.
- EW, derived, exponent width, ECW+2: 8 or 10.
- MW, derived, BCD coefficient width, 4*(3*ND+1): 28 or 64.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept an operand.
- operand  in  W  DPD-encoded decimal operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- S  out  1  sign.
- E  out  EW  biased exponent.
- M  out  MW  BCD coefficient, most significant digit in M[MW-1:MW-4].
- is_inf  out  1  operand is infinity.
- is_nan  out  1  operand is any NaN.
- is_snan  out  1  operand is a signalling NaN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0. S, E, M, is_inf, is_nan and is_snan are all 0. Internal declet counter is 0.
- Field positions: G = operand[W-2:W-6], written G0..G4 with G0 = operand[W-2]. Exponent continuation = operand[W-7:W-6-ECW]. Declet k (k=0 is most significant) = operand[10*(ND-k)-1 : 10*(ND-k)-10].
- FSM has three states: IDLE, DECODE, DONE.
- in_ready = (state==IDLE). It is registered-state driven, with no combinational path from out_ready.
- IDLE: on in_valid && in_ready, register the operand and S = operand[W-1], then go to DECODE with counter=0. Same edge also resolves G:
  - G0G1 != 11: E = {G0,G1,expcont}; MSD = {0,G2,G3,G4}.
  - G0G1 = 11 and G2G3 != 11: E = {G2,G3,expcont}; MSD = {100,G4}.
  - G0..G3 = 1111 and G4=0: is_inf=1, E=0, MSD=0, M forced to 0 at completion.
  - G0..G3 = 1111 and G4=1: is_nan=1, is_snan = operand[W-7], E=0, MSD=0. The declets are still decoded as the payload.
- DECODE: each cycle decodes declet[counter] into 3 BCD digits and writes M[MW-5-12*counter -: 12], then increments the counter. After the declet with counter=ND-1: go to DONE and set out_valid=1.
- Latency: out_valid is high exactly ND cycles after the accepting edge (2 for decimal32, 5 for decimal64). Throughput is one operand per ND+2 cycles when out_ready is held high.
- Declet decode, bits b9..b0, with a=b9:7, c=b6:4, d=b2:0:
  - b3=0 -> {0a},{0c},{0d}.
  - b3=1, b2:1=00 -> {0a},{0c},{100,b0}.
  - b3=1, b2:1=01 -> {0a},{100,b4},{0,b6:5,b0}.
  - b3=1, b2:1=10 -> {100,b7},{0c},{0,b9:8,b0}.
  - b3=1, b2:1=11, b6:5=00 -> {100,b7},{100,b4},{0,b9:8,b0}.
  - b3=1, b2:1=11, b6:5=01 -> {100,b7},{0,b9:8,b4},{100,b0}.
  - b3=1, b2:1=11, b6:5=10 -> {0a},{100,b4},{100,b0}.
  - b3=1, b2:1=11, b6:5=11 -> {100,b7},{100,b4},{100,b0}. Non-canonical b9:8 is ignored.
- DONE: all outputs hold stable while out_valid=1 && out_ready=0. On out_ready=1: out_valid goes to 0 and state returns to IDLE at that edge. Outputs keep their last value until the next acceptance. in_valid is ignored outside IDLE.
- Flags: is_inf, is_nan and is_snan are mutually consistent; is_snan implies is_nan. Flags clear at the next acceptance.
- rst asserted in any state: immediate return to reset values. A partially decoded operand is discarded and no out_valid pulse is produced.

Test Plan:
- W=32, operand 0x22500001 -> after 2 cycles: out_valid=1, S=0, E=8'h65, M=28'h0000001, all flags 0.
- W=32, operand 0x6E5FFFFF -> E=8'h65, M=28'h9999999. Also declet 0x0FF (non-canonical) placed in the low declet decodes to BCD 999.
- W=32, operands 0x78000000 / 0x7C000000 / 0x7E000001 -> is_inf=1, M=0; is_nan=1, is_snan=0; is_nan=1, is_snan=1, M=28'h0000001.
- W=64, operand 0x2238000000000001 -> out_valid exactly 5 cycles after acceptance, E=10'h18E, M=64'h1. Sweep all 1024 declets at position 4 against a reference DPD model.
- Backpressure: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, a new in_valid is not accepted. Releasing out_ready -> in_ready=1 on the next cycle.
- Assert rst during DECODE (cycle 1 of 5, W=64) -> in_ready=1 and all outputs 0 immediately. No out_valid appears. The next operand decodes correctly.
